// File: rtl/loop_buffer_ctrl.sv
// Loop buffer controller: detects short backward loops at IF/ID, captures one
// iteration of the body and replays it to decode while fetch is stalled.
module loop_buffer_ctrl #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ITER_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              mispredict,
  input  logic              ext_flush,
  input  logic              replay_ready,
  output logic              out_valid,
  output logic [31:0]       out_instr,
  output logic [XLEN-1:0]   out_pc,
  output logic              fetch_block,
  output logic              flush,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              loop_active,
  output logic [ITER_W-1:0] iter_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [XLEN-1:0] MAX_NEG = XLEN'(4 * (DEPTH - 1));

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_REPLAY, S_EXIT} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   br_pc_q, br_pc_d;
  logic [XLEN-1:0]   tgt_pc_q, tgt_pc_d;
  logic [PW-1:0]     len_m1_q, len_m1_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              flush_q, flush_d;
  logic [XLEN-1:0]   redirect_q, redirect_d;
  logic [31:0]       mem_q [DEPTH];

  logic [6:0]        opcode;
  logic              is_brjal, is_cf, detect;
  logic [XLEN-1:0]   neg_imm, fill_pc, rd_pc;
  logic              mem_we, fill_close;

  always_comb begin
    opcode   = in_instr[6:0];
    is_brjal = (opcode == OP_BR) || (opcode == OP_JAL);
    is_cf    = is_brjal || (opcode == OP_JALR);
    neg_imm  = '0 - in_imm;
    // A negative, word-aligned offset whose magnitude fits in DEPTH-1 words.
    detect   = in_valid && is_brjal && in_imm[XLEN-1] && (in_imm[1:0] == 2'b00)
               && (neg_imm <= MAX_NEG);
    fill_pc  = tgt_pc_q + XLEN'({wr_ptr_q, 2'b00});
    rd_pc    = tgt_pc_q + XLEN'({rd_ptr_q, 2'b00});
  end

  always_comb begin
    state_d    = state_q;
    br_pc_d    = br_pc_q;
    tgt_pc_d   = tgt_pc_q;
    len_m1_d   = len_m1_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    iter_d     = iter_q;
    flush_d    = 1'b0;
    redirect_d = '0;
    mem_we     = 1'b0;
    fill_close = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (detect) begin
          br_pc_d  = in_pc;
          tgt_pc_d = in_pc + in_imm;
          len_m1_d = neg_imm[PW+1:2];
          wr_ptr_d = '0;
          state_d  = S_FILL;
        end
      end
      S_FILL: begin
        if (in_valid) begin
          if (in_pc != fill_pc) begin
            state_d = S_IDLE;
          end else begin
            mem_we = 1'b1;
            if (wr_ptr_q == len_m1_q) begin
              if (in_pc == br_pc_q) begin
                fill_close = 1'b1;
                rd_ptr_d   = '0;
                iter_d     = '0;
                state_d    = S_REPLAY;
              end else begin
                state_d = S_IDLE;
              end
            end else if (is_cf) begin
              state_d = S_IDLE;
            end else begin
              wr_ptr_d = wr_ptr_q + PW'(1);
            end
          end
        end
      end
      S_REPLAY: begin
        if (mispredict) begin
          flush_d    = 1'b1;
          redirect_d = br_pc_q + XLEN'(4);
          state_d    = S_EXIT;
        end else if (replay_ready) begin
          if (rd_ptr_q == len_m1_q) begin
            rd_ptr_d = '0;
            if (iter_q != '1) iter_d = iter_q + ITER_W'(1);
          end else begin
            rd_ptr_d = rd_ptr_q + PW'(1);
          end
        end
      end
      S_EXIT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // ext_flush overrides everything, including a same-cycle mispredict exit.
    if (ext_flush) begin
      state_d    = S_IDLE;
      flush_d    = 1'b0;
      redirect_d = '0;
      fill_close = 1'b0;
      mem_we     = 1'b0;
      rd_ptr_d   = rd_ptr_q;
      iter_d     = iter_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      br_pc_q    <= '0;
      tgt_pc_q   <= '0;
      len_m1_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      iter_q     <= '0;
      flush_q    <= 1'b0;
      redirect_q <= '0;
    end else begin
      state_q    <= state_d;
      br_pc_q    <= br_pc_d;
      tgt_pc_q   <= tgt_pc_d;
      len_m1_q   <= len_m1_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      iter_q     <= iter_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= in_instr;
  end

  always_comb begin
    out_valid   = (state_q == S_REPLAY);
    loop_active = out_valid;
    out_instr   = out_valid ? mem_q[rd_ptr_q] : '0;
    out_pc      = out_valid ? rd_pc : '0;
    fetch_block = out_valid || fill_close;
    flush       = flush_q;
    redirect_pc = redirect_q;
    iter_count  = iter_q;
  end

endmodule

// File: tb/tb_loop_buffer_ctrl.sv
// Scoreboard bench for loop_buffer_ctrl: captured body entries are queued while
// filling and rotated through the queue as the DUT replays them.
module tb_loop_buffer_ctrl;
  localparam int XLEN   = 32;
  localparam int DEPTH  = 16;
  localparam int ITER_W = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [XLEN-1:0]   in_pc = '0;
  logic [31:0]       in_instr = '0;
  logic [XLEN-1:0]   in_imm = '0;
  logic              mispredict = 1'b0;
  logic              ext_flush = 1'b0;
  logic              replay_ready = 1'b1;
  logic              out_valid;
  logic [31:0]       out_instr;
  logic [XLEN-1:0]   out_pc;
  logic              fetch_block;
  logic              flush;
  logic [XLEN-1:0]   redirect_pc;
  logic              loop_active;
  logic [ITER_W-1:0] iter_count;

  loop_buffer_ctrl #(.XLEN(XLEN), .DEPTH(DEPTH), .ITER_W(ITER_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc),
    .in_instr(in_instr), .in_imm(in_imm), .mispredict(mispredict),
    .ext_flush(ext_flush), .replay_ready(replay_ready), .out_valid(out_valid),
    .out_instr(out_instr), .out_pc(out_pc), .fetch_block(fetch_block),
    .flush(flush), .redirect_pc(redirect_pc), .loop_active(loop_active),
    .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t              exp_q[$];
  int                checks = 0;
  int                errors = 0;
  logic [31:0]       cur_br;
  logic [ITER_W-1:0] m_iter;

  function automatic logic [31:0] body_word(input logic [31:0] pc);
    return {pc[24:0], 7'b0010011};
  endfunction
  function automatic logic [31:0] br_word(input logic [31:0] pc);
    return {pc[24:0], 7'b1100011};
  endfunction
  function automatic logic [31:0] jal_word(input logic [31:0] pc);
    return {pc[24:0], 7'b1101111};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] w,
                       input logic [31:0] imm);
    in_valid = v;
    in_pc    = pc;
    in_instr = w;
    in_imm   = imm;
  endtask

  // Detect + fill an n-entry loop closed by a BR at br_pc; queue expected entries.
  task automatic fill_loop(input logic [31:0] br_pc, input int n, input bit bubble);
    logic [31:0] imm, pc, w;
    ent_t e;
    imm = 32'(-(4 * (n - 1)));
    exp_q.delete();
    m_iter = '0;
    cur_br = br_pc;
    drive(1'b1, br_pc, br_word(br_pc), imm);
    @(negedge clk);
    checks++;
    if (fetch_block !== 1'b0) begin
      errors++;
      $display("FAIL detect_fetch_block got %b want 0", fetch_block);
    end
    tick();
    for (int i = 0; i < n; i++) begin
      if (bubble && i == 1) begin
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (fetch_block !== 1'b0) begin
          errors++;
          $display("FAIL fill_bubble_fetch_block got %b want 0", fetch_block);
        end
        tick();
      end
      pc = br_pc + imm + 32'(4 * i);
      w  = (i == n - 1) ? br_word(pc) : body_word(pc);
      drive(1'b1, pc, w, (i == n - 1) ? imm : 32'h0);
      e.pc = pc;
      e.instr = w;
      exp_q.push_back(e);
      @(negedge clk);
      checks++;
      if (fetch_block !== (i == n - 1) || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL fill_step%0d got fetch_block=%b out_valid=%b want %b 0",
                 i, fetch_block, out_valid, (i == n - 1));
      end
      tick();
    end
    drive(1'b0, '0, '0, '0);
  endtask

  // Replay n cycles with replay_ready taken from pat (LSB first, repeating).
  task automatic replay_steps(input int n, input logic [31:0] pat);
    ent_t e;
    for (int i = 0; i < n; i++) begin
      replay_ready = pat[i % 32];
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || loop_active !== 1'b1 || fetch_block !== 1'b1) begin
        errors++;
        $display("FAIL replay_flags got valid=%b active=%b fb=%b want 1 1 1",
                 out_valid, loop_active, fetch_block);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL replay_queue got empty want entries");
      end else if (out_pc !== exp_q[0].pc || out_instr !== exp_q[0].instr) begin
        errors++;
        $display("FAIL replay_entry got pc=%h instr=%h want pc=%h instr=%h",
                 out_pc, out_instr, exp_q[0].pc, exp_q[0].instr);
      end
      checks++;
      if (iter_count !== m_iter) begin
        errors++;
        $display("FAIL replay_iter got %0d want %0d", iter_count, m_iter);
      end
      if (replay_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        exp_q.push_back(e);
        if (e.pc == cur_br) m_iter++;
      end
      tick();
    end
    replay_ready = 1'b1;
  endtask

  task automatic ext_exit();
    ext_flush = 1'b1;
    tick();
    ext_flush = 1'b0;
    @(negedge clk);
    checks++;
    if (flush !== 1'b0 || out_valid !== 1'b0 || loop_active !== 1'b0 || fetch_block !== 1'b0) begin
      errors++;
      $display("FAIL ext_exit got flush=%b valid=%b active=%b fb=%b want 0 0 0 0",
               flush, out_valid, loop_active, fetch_block);
    end
    tick();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, out_instr, out_pc, fetch_block, flush, redirect_pc, loop_active, iter_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b instr=%h pc=%h fb=%b flush=%b redir=%h act=%b iter=%0d want all 0",
               out_valid, out_instr, out_pc, fetch_block, flush, redirect_pc, loop_active, iter_count);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fill_replay();
    fill_loop(32'h100, 4, 1'b1);
    replay_steps(10, 32'hFFFF_FFFF);
  endtask

  task automatic test_backpressure();
    replay_steps(12, 32'h9999_9999);
  endtask

  task automatic test_mispredict();
    for (int k = 0; k < 2 * DEPTH && exp_q[0].pc != cur_br; k++)
      replay_steps(1, 32'hFFFF_FFFF);
    checks++;
    if (exp_q[0].pc != cur_br) begin
      errors++;
      $display("FAIL mispredict_wait got front=%h want %h", exp_q[0].pc, cur_br);
    end
    mispredict   = 1'b1;
    replay_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== cur_br || flush !== 1'b0) begin
      errors++;
      $display("FAIL mispredict_cycle got valid=%b pc=%h flush=%b want 1 %h 0",
               out_valid, out_pc, flush, cur_br);
    end
    tick();
    mispredict = 1'b0;
    @(negedge clk);
    checks++;
    if (flush !== 1'b1 || redirect_pc !== cur_br + 32'd4 || out_valid !== 1'b0 || fetch_block !== 1'b0 || loop_active !== 1'b0) begin
      errors++;
      $display("FAIL exit_cycle got flush=%b redir=%h valid=%b fb=%b act=%b want 1 %h 0 0 0",
               flush, redirect_pc, out_valid, fetch_block, loop_active, cur_br + 32'd4);
    end
    checks++;
    if (iter_count !== m_iter) begin
      errors++;
      $display("FAIL exit_iter got %0d want %0d", iter_count, m_iter);
    end
    tick();
    @(negedge clk);
    checks++;
    if (flush !== 1'b0 || redirect_pc !== '0 || fetch_block !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_exit got flush=%b redir=%h fb=%b valid=%b want 0 0 0 0",
               flush, redirect_pc, fetch_block, out_valid);
    end
    tick();
  endtask

  // A rejected candidate followed directly by a valid 2-entry loop: the valid
  // loop only closes if the candidate left the controller in IDLE.
  task automatic test_reject(input logic [31:0] imm, input string name);
    drive(1'b1, 32'h300, br_word(32'h300), imm);
    @(negedge clk);
    checks++;
    if (fetch_block !== 1'b0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL %s_cand got fb=%b flush=%b want 0 0", name, fetch_block, flush);
    end
    tick();
    fill_loop(32'h400, 2, 1'b0);
    replay_steps(3, 32'hFFFF_FFFF);
    ext_exit();
  endtask

  // Loop whose fill is spoiled at body index 1; the closing BR re-detects.
  task automatic test_abort(input logic [31:0] bad_pc, input logic [31:0] bad_w, input string name);
    logic [31:0] pc, w;
    drive(1'b1, 32'h500, br_word(32'h500), 32'hFFFF_FFF4);
    tick();
    for (int i = 0; i < 4; i++) begin
      pc = 32'h4F4 + 32'(4 * i);
      w  = (i == 3) ? br_word(pc) : body_word(pc);
      if (i == 1) begin
        pc = bad_pc;
        w  = bad_w;
      end
      drive(1'b1, pc, w, (i == 3) ? 32'hFFFF_FFF4 : 32'h8);
      @(negedge clk);
      checks++;
      if (fetch_block !== 1'b0 || flush !== 1'b0) begin
        errors++;
        $display("FAIL %s_step%0d got fb=%b flush=%b want 0 0", name, i, fetch_block, flush);
      end
      tick();
    end
    drive(1'b0, '0, '0, '0);
    @(negedge clk);
    checks++;
    if (loop_active !== 1'b0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL %s_after got active=%b flush=%b want 0 0", name, loop_active, flush);
    end
    tick();
    ext_exit();
  endtask

  task automatic test_ext_with_mispredict();
    fill_loop(32'h100, 4, 1'b0);
    replay_steps(3, 32'hFFFF_FFFF);
    mispredict = 1'b1;
    ext_flush  = 1'b1;
    tick();
    mispredict = 1'b0;
    ext_flush  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (flush !== 1'b0 || redirect_pc !== '0 || out_valid !== 1'b0 || loop_active !== 1'b0 || fetch_block !== 1'b0) begin
        errors++;
        $display("FAIL ext_mispredict%0d got flush=%b redir=%h valid=%b act=%b fb=%b want all 0",
                 k, flush, redirect_pc, out_valid, loop_active, fetch_block);
      end
      tick();
    end
  endtask

  task automatic test_full_depth_reset();
    fill_loop(32'h1000, DEPTH, 1'b0);
    replay_steps(2 * DEPTH + 3, 32'hFFFF_FFFF);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_instr, out_pc, fetch_block, flush, redirect_pc, loop_active, iter_count} !== '0) begin
      errors++;
      $display("FAIL async_reset got valid=%b instr=%h pc=%h fb=%b flush=%b redir=%h act=%b iter=%0d want all 0",
               out_valid, out_instr, out_pc, fetch_block, flush, redirect_pc, loop_active, iter_count);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill_replay();
    test_backpressure();
    test_mispredict();
    test_reject(32'(-(4 * DEPTH)), "reject_too_far");
    test_reject(32'h0000_0010, "reject_positive");
    test_abort(32'h4F8, jal_word(32'h4F8), "jal_in_body");
    test_abort(32'h200, body_word(32'h200), "path_break");
    test_ext_with_mispredict();
    test_full_depth_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/loop_buffer_ctrl.md
# loop_buffer_ctrl

Parametrised loop buffer controller for the RISC-V front end. It sits between the IF/ID register and decode. It detects short backward-branch loops (B-type or JAL with a small negative offset) and captures one iteration of the loop body into an internal register array. It then replays that body to decode while fetch is stalled, and exits with a flush and redirect when the loop-closing branch mispredicts or an external redirect arrives.

## Interface
Parameters:
- XLEN, 32, width of PC and immediate
- DEPTH, 16, buffer entries (instructions); power of two, 4..64
- ITER_W, 16, width of the saturating iteration counter

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  IF/ID slot holds a valid instruction
- in_pc  in  XLEN  PC of in_instr
- in_instr  in  32  instruction word
- in_imm  in  XLEN  sign-extended branch/jump immediate for in_instr
- mispredict  in  1  loop-closing branch resolved not-taken
- ext_flush  in  1  pipeline redirect from elsewhere (trap, JALR, other mispredict)
- replay_ready  in  1  decode accepts out_instr this cycle
- out_valid  out  1  replayed instruction valid
- out_instr  out  32  replayed instruction
- out_pc  out  XLEN  PC of replayed instruction
- fetch_block  out  1  stall fetch / IF-ID
- flush  out  1  one-cycle pipeline flush request
- redirect_pc  out  XLEN  fetch target, valid while flush=1
- loop_active  out  1  high in REPLAY
- iter_count  out  ITER_W  completed replay iterations, saturating

## Operation
- States: IDLE, FILL, REPLAY, EXIT. Reset enters IDLE. All outputs, pointers and counters are 0 in reset.
- Control-flow opcodes: BR=1100011, JAL=1101111, JALR=1100111.
- IDLE detect condition, all must hold:
  - in_valid
  - opcode is BR or JAL
  - in_imm[XLEN-1]=1
  - in_imm[1:0]=0
  - (−in_imm) ≤ 4·(DEPTH−1)
- On detect, latch:
  - br_pc = in_pc
  - tgt_pc = in_pc + in_imm
  - len = ((−in_imm)>>2)+1 (entries, branch included)
  - wr_ptr = 0
  - go to FILL.
- FILL, per in_valid:
  - If in_pc ≠ tgt_pc + 4·wr_ptr, go to IDLE (abort, no flush).
  - Otherwise write mem[wr_ptr] = in_instr.
  - If wr_ptr < len−1 and the opcode is BR/JAL/JALR, abort to IDLE; the body must be a basic block.
  - If wr_ptr = len−1, the instruction must have in_pc = br_pc. Then go to REPLAY with rd_ptr=0 and iter_count=0.
  - Otherwise wr_ptr++.
- REPLAY:
  - out_valid=1, out_instr=mem[rd_ptr], out_pc=tgt_pc+4·rd_ptr.
  - On out_valid & replay_ready: if rd_ptr=len−1, rd_ptr←0 and iter_count++ (saturating at all ones); otherwise rd_ptr++.
  - in_valid/in_instr are ignored.
- mispredict in REPLAY goes to EXIT. The handshake in that cycle is not counted and rd_ptr holds.
- EXIT (one cycle): flush=1, redirect_pc=br_pc+4, out_valid=0, fetch_block=0, then IDLE.
- ext_flush in any state goes to IDLE next cycle, with no flush output and out_valid dropped. ext_flush has priority over mispredict.
- mispredict outside REPLAY is ignored.
- Address arithmetic is modulo 2^XLEN. Pointers are clog2(DEPTH) bits. len ranges 2..DEPTH; len=1 (imm=0) is excluded because it is not negative.

## Timing
- Detect in cycle N: state=FILL in N+1. The body's first instruction may arrive in N+1 or later; bubbles (in_valid=0) are allowed in FILL.
- Closing branch accepted in cycle M:
  - fetch_block=1 combinationally in M.
  - State is REPLAY in M+1, with out_valid=1 and out_instr=mem[0] in M+1.
  - Throughput is one instruction per cycle while replay_ready=1. out_* are stable while replay_ready=0.
- fetch_block = (state=REPLAY) | (FILL & closing-branch write this cycle).
- mispredict in cycle K (REPLAY):
  - flush=1 and redirect_pc valid in K+1.
  - State is IDLE and fetch_block=0 in K+2.
- flush and redirect_pc are registered outputs. They are 0 in all cycles except the EXIT cycle.
- Asynchronous reset mid-operation returns to IDLE immediately with all outputs 0. Buffer contents are don't-care.
- mem write and pointer updates are on the rising clk edge. mem read is combinational from registered rd_ptr.

## Test plan
- Detect+fill+replay:
  - Stimulus: BR at pc 0x100 with imm −12, followed by sequential instrs at 0xF4, 0xF8, 0xFC and BR at 0x100.
  - Response: len=4, then out_pc sequence 0xF4, 0xF8, 0xFC, 0x100, 0xF4…, iter_count increments on each 0x100 accepted.
- Backpressure:
  - Stimulus: replay_ready toggled 1,0,0,1.
  - Response: out_instr/out_pc held while ready=0, no skipped or duplicated entries.
- Mispredict exit:
  - Stimulus: mispredict pulsed in REPLAY with br_pc=0x100.
  - Response: one cycle later flush=1 and redirect_pc=0x104, then IDLE with fetch_block=0. rd_ptr is not advanced in the mispredict cycle.
- Rejections:
  - Stimulus: imm=−4·DEPTH, imm positive, and a JAL inside the body during FILL.
  - Response: no transition to FILL in the first two cases; the third returns to IDLE with flush=0.
- Path break and ext_flush:
  - Stimulus: in FILL, in_pc jumps to 0x200. Separately, ext_flush is asserted together with mispredict in REPLAY.
  - Response: the first aborts to IDLE. The second goes to IDLE with flush never asserted.
- Full depth and reset:
  - Stimulus: a DEPTH-entry loop, with imm=−4·(DEPTH−1). Then async reset asserted mid-REPLAY.
  - Response: the loop wraps rd_ptr DEPTH−1→0. After reset, all outputs are 0 immediately.
